// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates between instruction fetch and load/store
// requesters for a single-port RAM. It holds the granted address and write
// data for the whole access, strobes the RAM for a fixed number of cycles,
// and returns read data with a one-cycle acknowledge. Every output is a
// register or a decode of registered state.
module mem_access_ctrl #(
  parameter int RAM_LATENCY = 1,
  parameter int ADDR_W      = 9
) (
  input  logic              clock,
  input  logic              clear_n,
  // instruction fetch port (read only)
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  // load/store data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  // RAM side
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Four bits cover the whole legal latency range of 1..15.
  localparam logic [3:0] LAT = 4'(RAM_LATENCY);

  state_t              state_q,     state_d;
  logic [3:0]          cnt_q,       cnt_d;
  logic                last_d_q,    last_d_d;   // 1 = data port won last grant
  logic                owner_q,     owner_d;    // 1 = data port owns access
  logic                we_q,        we_d;       // 1 = write access
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         if_rdata_q,  if_rdata_d;
  logic [31:0]         d_rdata_q,   d_rdata_d;

  logic                grant_if;
  logic                grant_d;

  // Round-robin arbitration: on a tie the port that did not win last time goes.
  always_comb begin
    grant_if = if_req && (!d_req || last_d_q);
    grant_d  = d_req && !grant_if;
  end

  // Next-state logic for the access sequencer and its held datapath registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d_d    = last_d_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_if) begin
          // Upper address bits are outside the RAM and silently dropped.
          mem_addr_d = if_addr[ADDR_W-1:0];
          owner_d    = 1'b0;
          we_d       = 1'b0;
          last_d_d   = 1'b0;
          cnt_d      = LAT;
          state_d    = ACCESS;
        end else if (grant_d) begin
          mem_addr_d  = d_addr[ADDR_W-1:0];
          mem_wdata_d = d_wdata;
          owner_d     = 1'b1;
          we_d        = d_we;
          last_d_d    = 1'b1;
          cnt_d       = LAT;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          // RAM data is valid on the final strobe cycle; only the owner's
          // register is updated, and writes leave both untouched.
          if (!we_q) begin
            if (owner_q) d_rdata_d  = mem_rdata;
            else         if_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_d_q    <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_d_q    <= last_d_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Output decode from registered state only; no input reaches an output.
  always_comb begin
    busy      = (state_q != IDLE);
    mem_read  = (state_q == ACCESS) && !we_q;
    mem_write = (state_q == ACCESS) &&  we_q;
    if_ack    = (state_q == DONE)   && !owner_q;
    d_ack     = (state_q == DONE)   &&  owner_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl. Three instances run side by side with
// RAM latencies 1, 3 and 4; each has a combinational RAM model whose contents
// are a fixed function of the address.
module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]  clear_n;
  logic [2:0]  if_req, d_req, d_we;
  logic [31:0] if_addr   [3];
  logic [31:0] d_addr    [3];
  logic [31:0] d_wdata   [3];
  logic [2:0]  if_ack, d_ack, mem_read, mem_write, busy;
  logic [31:0] if_rdata  [3];
  logic [31:0] d_rdata   [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];
  logic [8:0]  mem_addr  [3];

  int n_pass  = 0;
  int n_total = 0;

  // RAM contents: 0xDEADBEEF at 0x105, otherwise the address itself.
  function automatic logic [31:0] ram_model(input logic [8:0] a);
    if (a == 9'h105) return 32'hDEADBEEF;
    return {23'd0, a};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_ctrl #(
      .RAM_LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
      .ADDR_W(9)
    ) u_dut (
      .clock    (clock),
      .clear_n  (clear_n[g]),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_ack   (if_ack[g]),
      .if_rdata (if_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_ack    (d_ack[g]),
      .d_rdata  (d_rdata[g]),
      .mem_addr (mem_addr[g]),
      .mem_read (mem_read[g]),
      .mem_write(mem_write[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .busy     (busy[g])
    );
    assign mem_rdata[g] = ram_model(mem_addr[g]);
  end

  task automatic wait_idle(input int k);
    int c;
    c = 0;
    while (busy[k] !== 1'b0 && c < 30) begin
      @(negedge clock);
      c++;
    end
    n_total++;
    if (busy[k] !== 1'b0) $display("FAIL wait_idle inst%0d: busy=%b after %0d cycles, need 0", k, busy[k], c);
    else n_pass++;
  endtask

  task automatic test_reset();
    clear_n = 3'b000;
    if_req  = 3'b111;
    d_req   = 3'b111;
    d_we    = 3'b000;
    for (int k = 0; k < 3; k++) begin
      if_addr[k] = 32'h0000_0011;
      d_addr[k]  = 32'h0000_0022;
      d_wdata[k] = 32'hA5A5_A5A5;
    end
    repeat (2) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({busy[k], if_ack[k], d_ack[k], mem_read[k], mem_write[k]} !== 5'b0) $display("FAIL reset_ctrl inst%0d: busy/ifack/dack/rd/wr=%b, need 00000", k, {busy[k], if_ack[k], d_ack[k], mem_read[k], mem_write[k]});
      else n_pass++;
      n_total++;
      if ({mem_addr[k], mem_wdata[k], if_rdata[k], d_rdata[k]} !== 105'd0) $display("FAIL reset_data inst%0d: addr=%h wdata=%h ifr=%h dr=%h, need 0", k, mem_addr[k], mem_wdata[k], if_rdata[k], d_rdata[k]);
      else n_pass++;
    end
    clear_n = 3'b111;
    @(negedge clock);
    if_req = 3'b000;
    d_req  = 3'b000;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (mem_read[k] !== 1'b1 || mem_addr[k] !== 9'h011 || busy[k] !== 1'b1) $display("FAIL first_grant inst%0d: rd=%b addr=%h busy=%b, need 1 011 1", k, mem_read[k], mem_addr[k], busy[k]);
      else n_pass++;
    end
    for (int k = 0; k < 3; k++) wait_idle(k);
  endtask

  task automatic test_fetch_read();
    @(negedge clock);
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h0000_0105;
    @(negedge clock);
    if_req[0] = 1'b0;
    n_total++;
    if (mem_addr[0] !== 9'h105 || mem_read[0] !== 1'b1 || mem_write[0] !== 1'b0 || if_ack[0] !== 1'b0) $display("FAIL fetch_access: addr=%h rd=%b wr=%b ack=%b, need 105 1 0 0", mem_addr[0], mem_read[0], mem_write[0], if_ack[0]);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (if_ack[0] !== 1'b1 || mem_read[0] !== 1'b0 || d_ack[0] !== 1'b0) $display("FAIL fetch_ack: ifack=%b rd=%b dack=%b, need 1 0 0", if_ack[0], mem_read[0], d_ack[0]);
    else n_pass++;
    n_total++;
    if (if_rdata[0] !== 32'hDEADBEEF) $display("FAIL fetch_rdata: got %h, need deadbeef", if_rdata[0]);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (if_ack[0] !== 1'b0 || busy[0] !== 1'b0 || if_rdata[0] !== 32'hDEADBEEF) $display("FAIL fetch_after: ack=%b busy=%b rdata=%h, need 0 0 deadbeef", if_ack[0], busy[0], if_rdata[0]);
    else n_pass++;
  endtask

  task automatic test_data_write();
    int wr_cnt, rd_cnt, ack_cnt;
    wr_cnt = 0; rd_cnt = 0; ack_cnt = 0;
    @(negedge clock);
    d_req[0]   = 1'b1;
    d_we[0]    = 1'b1;
    d_addr[0]  = 32'hFFFF_FE03;
    d_wdata[0] = 32'h1234_5678;
    @(negedge clock);
    d_req[0] = 1'b0;
    d_we[0]  = 1'b0;
    n_total++;
    if (mem_addr[0] !== 9'h003 || mem_wdata[0] !== 32'h1234_5678 || mem_write[0] !== 1'b1) $display("FAIL write_access: addr=%h wdata=%h wr=%b, need 003 12345678 1", mem_addr[0], mem_wdata[0], mem_write[0]);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      wr_cnt  += int'(mem_write[0]);
      rd_cnt  += int'(mem_read[0]);
      ack_cnt += int'(d_ack[0]);
      if (i < 3) @(negedge clock);
    end
    n_total++;
    if (wr_cnt != 1 || rd_cnt != 0 || ack_cnt != 1) $display("FAIL write_strobes: wr=%0d rd=%0d dack=%0d, need 1 0 1", wr_cnt, rd_cnt, ack_cnt);
    else n_pass++;
    n_total++;
    if (d_rdata[0] !== 32'd0 || mem_wdata[0] !== 32'h1234_5678 || mem_addr[0] !== 9'h003) $display("FAIL write_hold: drdata=%h wdata=%h addr=%h, need 0 12345678 003", d_rdata[0], mem_wdata[0], mem_addr[0]);
    else n_pass++;
  endtask

  task automatic test_contention();
    int cyc[$];
    int who[$];
    @(negedge clock);
    clear_n[0] = 1'b0;
    if_req[0]  = 1'b1;
    d_req[0]   = 1'b1;
    d_we[0]    = 1'b0;
    if_addr[0] = 32'h0000_0040;
    d_addr[0]  = 32'h0000_0080;
    @(negedge clock);
    clear_n[0] = 1'b1;
    for (int c = 1; c <= 20 && cyc.size() < 4; c++) begin
      @(negedge clock);
      if (if_ack[0]) begin cyc.push_back(c); who.push_back(0); end
      if (d_ack[0])  begin cyc.push_back(c); who.push_back(1); end
    end
    if_req[0] = 1'b0;
    d_req[0]  = 1'b0;
    n_total++;
    if (cyc.size() != 4) $display("FAIL contend_count: saw %0d acks, need 4", cyc.size());
    else begin
      n_pass++;
      n_total++;
      if (who[0] != 0 || who[1] != 1 || who[2] != 0 || who[3] != 1) $display("FAIL contend_order: got %0d%0d%0d%0d (0=IF), need 0101", who[0], who[1], who[2], who[3]);
      else n_pass++;
      n_total++;
      if (cyc[0] != 2 || cyc[1] != 5 || cyc[2] != 8 || cyc[3] != 11) $display("FAIL contend_spacing: cycles %0d %0d %0d %0d, need 2 5 8 11", cyc[0], cyc[1], cyc[2], cyc[3]);
      else n_pass++;
    end
    n_total++;
    if (if_rdata[0] !== 32'h40 || d_rdata[0] !== 32'h80) $display("FAIL contend_rdata: if=%h d=%h, need 40 80", if_rdata[0], d_rdata[0]);
    else n_pass++;
    wait_idle(0);
  endtask

  task automatic test_latency();
    int rd, wr, ackn, ack_at;
    rd = 0; wr = 0; ackn = 0; ack_at = 0;
    @(negedge clock);
    d_req[1]  = 1'b1;
    d_we[1]   = 1'b0;
    d_addr[1] = 32'h0000_00AA;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (i == 1) d_req[1] = 1'b0;
      rd += int'(mem_read[1]);
      wr += int'(mem_write[1]);
      if (d_ack[1]) begin
        ackn++;
        if (ack_at == 0) ack_at = i;
      end
    end
    n_total++;
    if (rd != 3 || wr != 0) $display("FAIL lat_strobe: rd=%0d wr=%0d, need 3 0", rd, wr);
    else n_pass++;
    n_total++;
    if (ackn != 1 || ack_at != 4) $display("FAIL lat_ack: count=%0d at=%0d, need 1 at 4", ackn, ack_at);
    else n_pass++;
    n_total++;
    if (d_rdata[1] !== 32'h0000_00AA || if_rdata[1] !== 32'h11) $display("FAIL lat_rdata: d=%h if=%h, need 000000aa 00000011", d_rdata[1], if_rdata[1]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int ackn, ack_at;
    ackn = 0; ack_at = 0;
    @(negedge clock);
    d_req[2]  = 1'b1;
    d_we[2]   = 1'b0;
    d_addr[2] = 32'h0000_0055;
    @(negedge clock);
    d_req[2] = 1'b0;
    n_total++;
    if (mem_read[2] !== 1'b1 || mem_addr[2] !== 9'h055) $display("FAIL mid_started: rd=%b addr=%h, need 1 055", mem_read[2], mem_addr[2]);
    else n_pass++;
    @(negedge clock);
    clear_n[2] = 1'b0;
    @(negedge clock);
    clear_n[2] = 1'b1;
    n_total++;
    if (mem_read[2] !== 1'b0 || mem_write[2] !== 1'b0 || busy[2] !== 1'b0 || mem_addr[2] !== 9'h000) $display("FAIL mid_reset: rd=%b wr=%b busy=%b addr=%h, need 0 0 0 000", mem_read[2], mem_write[2], busy[2], mem_addr[2]);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      ackn += int'(d_ack[2]) + int'(if_ack[2]);
    end
    n_total++;
    if (ackn != 0) $display("FAIL mid_noack: saw %0d acks, need 0", ackn);
    else n_pass++;
    if_req[2]  = 1'b1;
    if_addr[2] = 32'h0000_0010;
    for (int i = 1; i <= 12 && ack_at == 0; i++) begin
      @(negedge clock);
      if (i == 1) if_req[2] = 1'b0;
      if (if_ack[2]) ack_at = i;
    end
    n_total++;
    if (ack_at != 5) $display("FAIL mid_fetch_ack: at=%0d, need 5", ack_at);
    else n_pass++;
    n_total++;
    if (if_rdata[2] !== 32'h10 || d_rdata[2] !== 32'd0) $display("FAIL mid_fetch_rdata: if=%h d=%h, need 10 0", if_rdata[2], d_rdata[2]);
    else n_pass++;
  endtask

  initial begin
    clear_n = 3'b000;
    if_req  = 3'b000;
    d_req   = 3'b000;
    d_we    = 3'b000;
    for (int k = 0; k < 3; k++) begin
      if_addr[k] = 32'd0;
      d_addr[k]  = 32'd0;
      d_wdata[k] = 32'd0;
    end
    test_reset();
    test_fetch_read();
    test_data_write();
    test_contention();
    test_latency();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access controller for the CPU's single-port 512 x 32 RAM. It arbitrates between the instruction-fetch requester and the load/store data requester, and holds the granted 9-bit MAR address and the write data for the whole access. It sequences the RAM read/write strobes for a fixed latency, then returns read data with a one-cycle acknowledge. It sits between the control unit/datapath and the RAM, and replaces the direct combinational MAR-to-RAM address path.

## Interface
Parameters:
- RAM_LATENCY, 1: cycles the strobe is held before read data is valid or a write is complete; legal range 1..15.
- ADDR_W, 9: RAM address width; the address is the low ADDR_W bits of the 32-bit request address.

Ports (one clock; reset is synchronous and active-low):
- clock  in  1  system clock; all state updates on the rising edge.
- clear_n  in  1  synchronous active-low reset.
- if_req  in  1  fetch request; read only.
- if_addr  in  32  fetch address.
- if_ack  out  1  one-cycle completion pulse for a fetch.
- if_rdata  out  32  fetch read data; registered.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read; sampled at grant.
- d_addr  in  32  data address.
- d_wdata  in  32  store data; sampled at grant.
- d_ack  out  1  one-cycle completion pulse for a data access.
- d_rdata  out  32  load data; registered.
- mem_addr  out  ADDR_W  registered MAR value to the RAM.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mem_wdata  out  32  registered write data to the RAM.
- mem_rdata  in  32  RAM read data.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant round-robin: the requester not granted last wins.
  - The last-grant register resets to "data", so fetch wins the first tie.
  - On grant: mem_addr <= addr[ADDR_W-1:0] (bits 31:ADDR_W are discarded, no error); mem_wdata <= d_wdata (data grant only); latch op (fetch = read) and owner; cnt <= RAM_LATENCY; go to ACCESS.
- ACCESS:
  - mem_read (read op) or mem_write (write op) is high in every ACCESS cycle. Never both.
  - cnt decrements each edge. At the edge where cnt == 1:
    - On a read, capture mem_rdata into the owner's rdata register.
    - Go to DONE.
- DONE:
  - The owner's ack is high for exactly this cycle.
  - Strobes are low.
  - Go to IDLE unconditionally.
- Requesters must drop req in the cycle after ack. A req still high in IDLE is treated as a new request.
- if_rdata and d_rdata hold their value until the next completed read by the same port. A data write leaves d_rdata unchanged.
- mem_addr and mem_wdata hold their value after a transaction until the next grant.
- Reset: clear_n low at an edge forces the following, regardless of state:
  - State to IDLE.
  - mem_addr, mem_wdata, if_rdata and d_rdata to 0.
  - mem_read, mem_write, if_ack, d_ack and busy to 0.
  - Last-grant to "data".
- An in-flight transaction is abandoned with no ack. A partially written RAM word is accepted.
- req inputs are ignored while clear_n is low.

## Timing
- Grant edge E: the IDLE edge that samples req.
- mem_addr and the strobe are valid from just after E through edge E+RAM_LATENCY.
- Read data is captured at edge E+RAM_LATENCY. ack is high from E+RAM_LATENCY to E+RAM_LATENCY+1.
- Transaction period is RAM_LATENCY+2 cycles (IDLE, ACCESS x RAM_LATENCY, DONE). With both requesters continuously active, grants alternate.
- There are no combinational paths from inputs to outputs. All outputs are registered or decoded from state only.
- mem_rdata must be stable at edge E+RAM_LATENCY.

## Test plan
- **Reset:** clear_n low 2 cycles with if_req = d_req = 1.
  - Required: all outputs 0; no ack; busy 0.
  - First grant after release goes to fetch.
- **Fetch read (RAM_LATENCY = 1):** if_addr = 0x0000_0105; RAM model holds 0xDEADBEEF at 0x105.
  - Required: mem_addr = 0x105 and mem_read high for 1 cycle.
  - if_ack pulses 1 edge after grant; if_rdata = 0xDEADBEEF.
- **Data write (RAM_LATENCY = 1):** d_we = 1, d_addr = 0xFFFF_FE03, d_wdata = 0x1234_5678.
  - Required: mem_addr = 0x003 and mem_wdata = 0x1234_5678; mem_write high 1 cycle; mem_read never high.
  - d_ack pulses once; d_rdata unchanged.
- **Contention:** both reqs held high from reset release, each requester re-raising req the cycle after its ack.
  - Required: grant order IF, D, IF, D.
  - With RAM_LATENCY = 1, the acks are spaced 3 cycles apart.
- **Latency (RAM_LATENCY = 3):** data read of 0x0AA, model returns 0x0000_00AA.
  - Required: mem_read high exactly 3 cycles; d_ack 3 edges after grant; d_rdata = 0x0000_00AA.
- **Reset mid-access (RAM_LATENCY = 4):** clear_n low for one edge during the 2nd ACCESS cycle.
  - Required: strobes 0 after that edge and no ack.
  - A following fetch of 0x010 completes normally.
